// File: rtl/drag_tree_pkg.sv
// Shared types and default build constants for the multi-lane drag-race tree.
package drag_tree_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_GREEN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int unsigned DEF_LANES      = 2;
   localparam int unsigned DEF_AMBERS     = 3;
   localparam int unsigned DEF_TICK_DIV   = 5000000;
   localparam int unsigned DEF_STEP_TICKS = 5;
   localparam int unsigned DEF_PRO_TICKS  = 4;
   localparam int unsigned DEF_RW         = 10;

   // Index width that never collapses to zero bits.
   function automatic int unsigned idx_w(input int unsigned n);
      if (n > 1) return $clog2(n);
      return 1;
   endfunction

endpackage

// File: rtl/drag_tick_gen.sv
// Timing-tick prescaler: one-cycle pulse every TICK_DIV enabled cycles, zeroed by restart.
module drag_tick_gen #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic restart,
   output logic tick_c
);

   localparam int unsigned CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      tick_c = 1'b0;
      if (restart) begin
         cnt_d = '0;
      end else if (en) begin
         if (cnt_q == CW'(TICK_DIV - 1)) begin
            cnt_d  = '0;
            tick_c = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/drag_tree_multi.sv
// Multi-lane drag-race christmas tree: amber countdown, green, false-start and launch detection.
// Define DRAG_TREE_REACTION_EN to build the per-lane reaction counters and winner logic.
module drag_tree_multi
   import drag_tree_pkg::*;
#(
   parameter int unsigned LANES      = DEF_LANES,
   parameter int unsigned AMBERS     = DEF_AMBERS,
   parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
   parameter int unsigned STEP_TICKS = DEF_STEP_TICKS,
   parameter int unsigned PRO_TICKS  = DEF_PRO_TICKS,
   parameter int unsigned RW         = DEF_RW
) (
   input  logic                      CLOCK_50,
   input  logic                      RESET_N,
   input  logic [LANES-1:0]          prestage,
   input  logic [LANES-1:0]          stage,
   input  logic                      go,
   input  logic                      mode,
   input  logic                      clr,
   output logic [LANES-1:0]          pre_lt,
   output logic [LANES-1:0]          stg_lt,
   output logic [LANES-1:0]          grn_lt,
   output logic [LANES-1:0]          red_lt,
   output logic [AMBERS-1:0]         amb_lt,
   output logic [LANES*RW-1:0]       react,
   output logic [idx_w(LANES)-1:0]   win,
   output logic                      win_vld,
   output logic                      busy
);

   localparam int unsigned AW   = idx_w(AMBERS);
   localparam int unsigned SMAX = (STEP_TICKS > PRO_TICKS) ? STEP_TICKS : PRO_TICKS;
   localparam int unsigned SW   = idx_w(SMAX);

   state_e            state_q, state_d;
   logic              mode_q, mode_d;
   logic [AW-1:0]     amb_idx_q, amb_idx_d;
   logic [SW-1:0]     step_q, step_d;
   logic [LANES-1:0]  pre_q, pre_d, stg_q, stg_d;
   logic [LANES-1:0]  grn_q, grn_d, red_q, red_d, lch_q, lch_d;
   logic [AMBERS-1:0] amb_q, amb_d;
   logic              busy_q, busy_d;

   logic [LANES-1:0]  fall_c;
   logic [SW-1:0]     last_c;
   logic              start_c, tick_c, tick_en_c;

   drag_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (CLOCK_50),
      .rst_n   (RESET_N),
      .en      (tick_en_c),
      .restart (start_c),
      .tick_c  (tick_c)
   );

   assign tick_en_c = (state_q == ST_COUNT) || (state_q == ST_GREEN);
   assign fall_c    = stg_q & ~stage;
   assign last_c    = mode_q ? SW'(PRO_TICKS - 1) : SW'(STEP_TICKS - 1);
   assign start_c   = (state_q == ST_IDLE) && go && (&stage);

   // Sequencer next state and lamp bookkeeping.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      amb_idx_d = amb_idx_q;
      step_d    = step_q;
      pre_d     = prestage;
      stg_d     = stage;
      grn_d     = grn_q;
      red_d     = red_q;
      lch_d     = lch_q;
      amb_d     = '0;
      busy_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_c) begin
               state_d   = ST_COUNT;
               mode_d    = mode;
               amb_idx_d = '0;
               step_d    = '0;
            end
         end
         ST_COUNT: begin
            if (tick_c) begin
               if (step_q == last_c) begin
                  step_d = '0;
                  if (mode_q || (amb_idx_q == AW'(AMBERS - 1))) state_d = ST_GREEN;
                  else amb_idx_d = amb_idx_q + AW'(1);
               end else begin
                  step_d = step_q + SW'(1);
               end
            end
            // A launch coinciding with green entry is a legal launch, not a foul.
            if (state_d == ST_GREEN) begin
               grn_d = ~red_q;
               lch_d = fall_c & ~red_q;
            end else begin
               red_d = red_q | fall_c;
            end
         end
         ST_GREEN: begin
            lch_d = lch_q | (fall_c & ~red_q);
            if (&(red_q | lch_d)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (clr) begin
               state_d = ST_IDLE;
               grn_d   = '0;
               red_d   = '0;
               lch_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_COUNT) amb_d = mode_d ? '1 : (AMBERS'(1) << amb_idx_d);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= ST_IDLE;
         mode_q    <= 1'b0;
         amb_idx_q <= '0;
         step_q    <= '0;
         pre_q     <= '0;
         stg_q     <= '0;
         grn_q     <= '0;
         red_q     <= '0;
         lch_q     <= '0;
         amb_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         amb_idx_q <= amb_idx_d;
         step_q    <= step_d;
         pre_q     <= pre_d;
         stg_q     <= stg_d;
         grn_q     <= grn_d;
         red_q     <= red_d;
         lch_q     <= lch_d;
         amb_q     <= amb_d;
         busy_q    <= busy_d;
      end
   end

   assign pre_lt = pre_q;
   assign stg_lt = stg_q;
   assign grn_lt = grn_q;
   assign red_lt = red_q;
   assign amb_lt = amb_q;
   assign busy   = busy_q;

`ifdef DRAG_TREE_REACTION_EN
   localparam int unsigned WW = idx_w(LANES);

   logic [LANES-1:0][RW-1:0] react_q, react_d;
   logic [WW-1:0]            win_q, win_d;
   logic                     win_vld_q, win_vld_d;
   logic [RW-1:0]            best_c;

   // Reaction counting in green; winner resolved on the transition into DONE.
   always_comb begin
      react_d   = react_q;
      win_d     = win_q;
      win_vld_d = win_vld_q;
      best_c    = '0;
      if (state_q == ST_GREEN) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (tick_c && !red_q[i] && !lch_d[i] && (react_q[i] != '1))
               react_d[i] = react_q[i] + RW'(1);
         end
         if (state_d == ST_DONE) begin
            win_d     = '0;
            win_vld_d = 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
               if (!red_q[i] && (!win_vld_d || (react_d[i] < best_c))) begin
                  best_c    = react_d[i];
                  win_d     = WW'(i);
                  win_vld_d = 1'b1;
               end
            end
         end
      end else if ((state_q == ST_DONE) && clr) begin
         react_d   = '0;
         win_d     = '0;
         win_vld_d = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         react_q   <= '0;
         win_q     <= '0;
         win_vld_q <= 1'b0;
      end else begin
         react_q   <= react_d;
         win_q     <= win_d;
         win_vld_q <= win_vld_d;
      end
   end

   assign react   = react_q;
   assign win     = win_q;
   assign win_vld = win_vld_q;
`else
   assign react   = '0;
   assign win     = '0;
   assign win_vld = 1'b0;
`endif

endmodule

// File: tb/tb_drag_tree_multi.sv
// Scoreboard bench for drag_tree_multi with a fast tick (LANES=2, AMBERS=3, TICK_DIV=4).
module tb_drag_tree_multi;

   localparam int unsigned LANES      = 2;
   localparam int unsigned AMBERS     = 3;
   localparam int unsigned TICK_DIV   = 4;
   localparam int unsigned STEP_TICKS = 2;
   localparam int unsigned PRO_TICKS  = 4;
   localparam int unsigned RW         = 10;
`ifdef DRAG_TREE_REACTION_EN
   localparam bit REACT_ON = 1'b1;
`else
   localparam bit REACT_ON = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]  pre;
      logic [1:0]  stg;
      logic [1:0]  grn;
      logic [1:0]  red;
      logic [2:0]  amb;
      logic [19:0] react;
      logic        win;
      logic        win_vld;
      logic        busy;
   } snap_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  prestage, stage;
   logic        go, mode, clr;
   logic [1:0]  pre_lt, stg_lt, grn_lt, red_lt;
   logic [2:0]  amb_lt;
   logic [19:0] react;
   logic [0:0]  win;
   logic        win_vld, busy;

   snap_t sb_q[$];
   int    n_cmp = 0;
   int    n_err = 0;

   drag_tree_multi #(
      .LANES(LANES), .AMBERS(AMBERS), .TICK_DIV(TICK_DIV),
      .STEP_TICKS(STEP_TICKS), .PRO_TICKS(PRO_TICKS), .RW(RW)
   ) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .prestage (prestage),
      .stage    (stage),
      .go       (go),
      .mode     (mode),
      .clr      (clr),
      .pre_lt   (pre_lt),
      .stg_lt   (stg_lt),
      .grn_lt   (grn_lt),
      .red_lt   (red_lt),
      .amb_lt   (amb_lt),
      .react    (react),
      .win      (win),
      .win_vld  (win_vld),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected snapshot; reaction fields only exist when the feature is built.
   function automatic snap_t mk(input logic [1:0] p, input logic [1:0] s, input logic [1:0] g,
                                input logic [1:0] r, input logic [2:0] a, input logic [9:0] r1,
                                input logic [9:0] r0, input logic w, input logic v, input logic b);
      snap_t e;
      e.pre     = p;
      e.stg     = s;
      e.grn     = g;
      e.red     = r;
      e.amb     = a;
      e.react   = REACT_ON ? {r1, r0} : 20'd0;
      e.win     = REACT_ON ? w : 1'b0;
      e.win_vld = REACT_ON ? v : 1'b0;
      e.busy    = b;
      return e;
   endfunction

   function automatic snap_t obs();
      snap_t o;
      o.pre = pre_lt; o.stg = stg_lt; o.grn = grn_lt; o.red = red_lt; o.amb = amb_lt;
      o.react = react; o.win = win[0]; o.win_vld = win_vld; o.busy = busy;
      return o;
   endfunction

   task automatic test_reset();
      snap_t got, exp;
      sb_q.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      got = obs(); exp = sb_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL reset got=%h exp=%h", got, exp); end
      rst_n = 1'b1;
   endtask

   // Sequential ambers, go/mode changes after start ignored, clr ignored mid-count, tied launch.
   task automatic test_sportsman();
      snap_t got, exp;
      @(negedge clk);
      prestage = 2'b11; stage = 2'b11; mode = 1'b0; go = 1'b1;
      for (int c = 0; c < 24; c++)
         sb_q.push_back(mk(2'b11, 2'b11, 2'b00, 2'b00, 3'(1 << (c / 8)), 10'd0, 10'd0, 1'b0, 1'b0, 1'b1));
      sb_q.push_back(mk(2'b11, 2'b11, 2'b11, 2'b00, 3'b000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1));
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         got = obs(); exp = sb_q.pop_front(); n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL sportsman c=%0d got=%h exp=%h", c, got, exp); end
         if (c == 0) begin go = 1'b0; mode = 1'b1; end
         if (c == 5) clr = 1'b1;
         if (c == 6) clr = 1'b0;
      end
      repeat (8) @(negedge clk);
      stage = 2'b00;
      sb_q.push_back(mk(2'b11, 2'b00, 2'b11, 2'b00, 3'b000, 10'd2, 10'd2, 1'b0, 1'b1, 1'b1));
      sb_q.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 3'b000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0));
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         got = obs(); exp = sb_q.pop_front(); n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL tie_done c=%0d got=%h exp=%h", c, got, exp); end
         clr = (c == 0);
      end
   endtask

   // Pro tree with a lane-1 foul during amber and lane 0 launching after three ticks.
   task automatic test_pro_false_start();
      snap_t got, exp;
      @(negedge clk);
      prestage = 2'b11; stage = 2'b11; mode = 1'b1; go = 1'b1;
      for (int c = 0; c < 16; c++)
         sb_q.push_back(mk(2'b11, (c <= 4) ? 2'b11 : 2'b01, 2'b00, (c <= 4) ? 2'b00 : 2'b10,
                           3'b111, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1));
      sb_q.push_back(mk(2'b11, 2'b01, 2'b01, 2'b10, 3'b000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1));
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         got = obs(); exp = sb_q.pop_front(); n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL pro c=%0d got=%h exp=%h", c, got, exp); end
         if (c == 0) begin go = 1'b0; mode = 1'b0; end
         if (c == 4) stage = 2'b01;
      end
      repeat (12) @(negedge clk);
      stage = 2'b00;
      sb_q.push_back(mk(2'b11, 2'b00, 2'b01, 2'b10, 3'b000, 10'd0, 10'd3, 1'b0, 1'b1, 1'b1));
      sb_q.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 3'b000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0));
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         got = obs(); exp = sb_q.pop_front(); n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL pro_done c=%0d got=%h exp=%h", c, got, exp); end
         clr = (c == 0);
      end
   endtask

   // Both lanes foul; clr held from late amber must only act once DONE is reached.
   task automatic test_both_false_start();
      snap_t got, exp;
      @(negedge clk);
      prestage = 2'b11; stage = 2'b11; mode = 1'b0; go = 1'b1;
      for (int c = 0; c < 24; c++)
         sb_q.push_back(mk(2'b11, (c <= 10) ? 2'b11 : 2'b00, 2'b00, (c <= 10) ? 2'b00 : 2'b11,
                           3'(1 << (c / 8)), 10'd0, 10'd0, 1'b0, 1'b0, 1'b1));
      for (int c = 24; c < 26; c++)
         sb_q.push_back(mk(2'b11, 2'b00, 2'b00, 2'b11, 3'b000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1));
      sb_q.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0));
      for (int c = 0; c < 27; c++) begin
         @(negedge clk);
         got = obs(); exp = sb_q.pop_front(); n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL both_red c=%0d got=%h exp=%h", c, got, exp); end
         if (c == 0)  go = 1'b0;
         if (c == 10) stage = 2'b00;
         if (c == 23) clr = 1'b1;
         if (c == 25) prestage = 2'b00;
      end
      clr = 1'b0;
   endtask

   // Reset asserted during the second amber, then go without a full stage is ignored.
   task automatic test_reset_mid();
      snap_t got, exp;
      @(negedge clk);
      prestage = 2'b11; stage = 2'b11; mode = 1'b0; go = 1'b1;
      for (int c = 0; c < 12; c++)
         sb_q.push_back(mk(2'b11, 2'b11, 2'b00, 2'b00, 3'(1 << (c / 8)), 10'd0, 10'd0, 1'b0, 1'b0, 1'b1));
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         got = obs(); exp = sb_q.pop_front(); n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL pre_reset c=%0d got=%h exp=%h", c, got, exp); end
         if (c == 0) go = 1'b0;
      end
      rst_n = 1'b0;
      sb_q.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0));
      sb_q.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0));
      #1;
      for (int c = 0; c < 2; c++) begin
         if (c == 1) @(negedge clk);
         got = obs(); exp = sb_q.pop_front(); n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL mid_reset c=%0d got=%h exp=%h", c, got, exp); end
      end
      rst_n = 1'b1; prestage = 2'b01; stage = 2'b01; go = 1'b1;
      for (int c = 0; c < 6; c++)
         sb_q.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0));
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         got = obs(); exp = sb_q.pop_front(); n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL partial_stage c=%0d got=%h exp=%h", c, got, exp); end
      end
      go = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; prestage = 2'b00; stage = 2'b00; go = 1'b0; mode = 1'b0; clr = 1'b0;
      test_reset();
      test_sportsman();
      test_pro_false_start();
      test_both_false_start();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
